// File: rtl/top_level.sv
// top_level: pattern-count engine.
// On a req pulse it reads pattern P from dm1.core[32][4:0] and scans the
// 32-byte message in dm1.core[0..31], treated as a 256-bit stream with
// byte 0 bit 7 first. It then writes three 8-bit counts back to data memory:
//   dm[33] = CTB : in-byte 5-bit window matches (4 per byte)
//   dm[34] = CTO : bytes with at least one in-byte match
//   dm[35] = CTS : matches over all 252 stream windows
// After the writes it raises done.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   req   - start request, level-sampled in IDLE/DONE
//   done  - high once results are written; held until the next start

// Instruction ROM. It is loaded from outside and is not used by the engine yet.
module irom #(
  parameter int IW     = 9,
  parameter int IDEPTH = 1024
) (
  input  logic [$clog2(IDEPTH)-1:0] addr,
  output logic [IW-1:0]             data
);
  logic [IW-1:0] core [IDEPTH];
  assign data = core[addr];
endmodule

// Byte-wide data memory: combinational read, synchronous write.
// It is never cleared by reset.
module dmem #(
  parameter int DDEPTH = 256
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [$clog2(DDEPTH)-1:0] addr,
  input  logic [7:0]                wdata,
  output logic [7:0]                rdata
);
  logic [7:0] core [DDEPTH];
  assign rdata = core[addr];
  always_ff @(posedge clk) begin
    if (we) core[addr] <= wdata;
  end
endmodule

module top_level #(
  parameter int IW     = 9,
  parameter int IDEPTH = 1024,
  parameter int DDEPTH = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic done
);
  localparam int IAW = $clog2(IDEPTH);
  localparam int DAW = $clog2(DDEPTH);

  typedef enum logic [2:0] {IDLE, LDPAT, SCAN, WR33, WR34, WR35, DONE} state_t;

  state_t       state;
  logic [4:0]   idx;
  logic [4:0]   pat;
  logic [7:0]   prev;
  logic [7:0]   ctb, cto, cts;

  logic           we;
  logic [DAW-1:0] addr;
  logic [7:0]     wdata, rdata;
  logic [2:0]     byte_hits, cross_hits;
  logic [IW-1:0]  insn_unused;

  irom #(.IW(IW), .IDEPTH(IDEPTH)) ir1 (
    .addr ({IAW{1'b0}}),
    .data (insn_unused)
  );

  dmem #(.DDEPTH(DDEPTH)) dm1 (
    .clk   (clk),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  // Matches of p against the four windows lying wholly inside byte b.
  function automatic logic [2:0] in_matches(input logic [7:0] b, input logic [4:0] p);
    logic [2:0] n;
    n = '0;
    for (int s = 0; s < 4; s++) begin
      if (5'(b >> s) == p) n = n + 3'd1;
    end
    return n;
  endfunction

  // Matches of p against the four windows that start in byte a and end in the following byte b.
  function automatic logic [2:0] cross_matches(input logic [7:0] a, input logic [7:0] b,
                                               input logic [4:0] p);
    logic [2:0]  n;
    logic [15:0] pair;
    n    = '0;
    pair = {a, b};
    // Window starting at a[3] is pair[11:7]; each later one shifts down by one bit.
    for (int s = 4; s < 8; s++) begin
      if (5'(pair >> s) == p) n = n + 3'd1;
    end
    return n;
  endfunction

  // Memory port steering, decoded from the current state.
  always_comb begin
    we    = 1'b0;
    addr  = DAW'(idx);
    wdata = ctb;
    unique case (state)
      LDPAT: addr = DAW'(32);
      WR33:  begin we = 1'b1; addr = DAW'(33); wdata = ctb; end
      WR34:  begin we = 1'b1; addr = DAW'(34); wdata = cto; end
      WR35:  begin we = 1'b1; addr = DAW'(35); wdata = cts; end
      default: ;
    endcase
  end

  always_comb begin
    byte_hits  = in_matches(rdata, pat);
    cross_hits = (idx == 5'd0) ? 3'd0 : cross_matches(prev, rdata, pat);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
      idx   <= '0;
      pat   <= '0;
      prev  <= '0;
      ctb   <= '0;
      cto   <= '0;
      cts   <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (req) begin
            state <= LDPAT;
            done  <= 1'b0;
            idx   <= '0;
            prev  <= '0;
            ctb   <= '0;
            cto   <= '0;
            cts   <= '0;
          end
        end
        LDPAT: begin
          pat   <= rdata[4:0];
          idx   <= '0;
          state <= SCAN;
        end
        SCAN: begin
          ctb  <= ctb + 8'(byte_hits);
          cto  <= cto + ((byte_hits != 3'd0) ? 8'd1 : 8'd0);
          cts  <= cts + 8'(byte_hits) + 8'(cross_hits);
          prev <= rdata;
          idx  <= idx + 5'd1;
          if (idx == 5'd31) state <= WR33;
        end
        WR33: state <= WR34;
        WR34: state <= WR35;
        WR35: begin
          state <= DONE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_top_level.sv
// Bench for top_level. It loads the data memory hierarchically, pulses req and
// waits a bounded number of cycles for done. It then checks latency and the three
// counts against a model that scans the 256-bit stream window by window.
module tb_top_level;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0;
  logic done;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] msg [32];
  logic [7:0] patbyte;

  top_level dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: count over the stream definition directly.
  task automatic model(output int ctb, output int cto, output int cts);
    logic       bits [256];
    logic [4:0] p, w;
    int         hits;
    p   = patbyte[4:0];
    ctb = 0; cto = 0; cts = 0;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 8; j++)
        bits[8*i + j] = msg[i][7-j];
    for (int k = 0; k < 252; k++) begin
      for (int t = 0; t < 5; t++) w[4-t] = bits[k + t];
      if (w == p) cts++;
    end
    for (int i = 0; i < 32; i++) begin
      hits = 0;
      // In-byte windows start at stream offsets 0..3 within the byte.
      for (int o = 0; o < 4; o++) begin
        for (int t = 0; t < 5; t++) w[4-t] = bits[8*i + o + t];
        if (w == p) hits++;
      end
      ctb += hits;
      if (hits > 0) cto++;
    end
  endtask

  task automatic load_mem();
    for (int i = 0; i < 32; i++) dut.dm1.core[i] = msg[i];
    dut.dm1.core[32] = patbyte;
    dut.dm1.core[33] = 8'h00;
    dut.dm1.core[34] = 8'h00;
    dut.dm1.core[35] = 8'h00;
  endtask

  task automatic run(input string tag);
    int n, e_ctb, e_cto, e_cts;
    bit seen_low;
    model(e_ctb, e_cto, e_cts);
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    n = 1;
    seen_low = (done == 1'b0);
    while (done !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 2) seen_low = seen_low && (done == 1'b0);
    end
    chk({tag, ".done_low"}, int'(seen_low), 1);
    chk({tag, ".latency"}, n, 37);
    chk({tag, ".ctb"}, int'(dut.dm1.core[33]), e_ctb);
    chk({tag, ".cto"}, int'(dut.dm1.core[34]), e_cto);
    chk({tag, ".cts"}, int'(dut.dm1.core[35]), e_cts);
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 32; i++) msg[i] = v;
  endtask

  initial begin
    #12;
    chk("reset.done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle.done", int'(done), 0);

    fill(8'h00); patbyte = 8'h00; load_mem(); run("zeros");
    fill(8'h55); patbyte = 8'h15; load_mem(); run("alt55");
    fill(8'h00); msg[0] = 8'hF8; patbyte = 8'h1F; load_mem(); run("f8_p1f");
    patbyte = 8'h00; load_mem(); run("f8_p00");
    fill(8'hFF); patbyte = 8'hFF; load_mem(); run("ones");

    // Back-to-back run from DONE with result bytes cleared.
    chk("done.hold", int'(done), 1);
    load_mem(); run("again");

    // Reset during SCAN: done drops immediately; result bytes untouched.
    for (int i = 0; i < 32; i++) msg[i] = 8'($urandom);
    patbyte = 8'($urandom);
    load_mem();
    dut.dm1.core[33] = 8'hAA;
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset.done", int'(done), 0);
    @(negedge clk);
    chk("midreset.dm33", int'(dut.dm1.core[33]), 8'hAA);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midreset.idle", int'(done), 0);
    load_mem(); run("after_reset");

    // Random messages, with some biased toward sparse bytes so matches occur often.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 32; i++) begin
        msg[i] = 8'($urandom);
        if (r[0]) msg[i] = msg[i] & 8'($urandom);
      end
      patbyte = 8'($urandom);
      load_mem();
      run($sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
